regfile_wr_arbiter: RTL and testbench
=====================================

# regfile_wr_arbiter

Shares the register file's single write port between up to NUM_REQ writeback sources (ALU result, load data, link/JAL, ...) with round-robin arbitration and a valid/ready handshake. After reset it optionally sequences a full clear of all 32 registers before accepting any traffic. It sits between the writeback stage and the register file, driving that block's `ctrl_regwrite`, `write_w` and `write_data_w` inputs directly from flops.

## Interface
- `NUM_REQ`, default 3: number of writeback requesters, 2..8.
- `CLEAR_ON_RESET`, default 1: 1 = run the 32-cycle zeroing sequence after reset; 0 = go straight to arbitration.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  NUM_REQ  per-requester write request.
- `req_addr`  in  NUM_REQ*5  packed destination register index; requester i uses bits [5i+4:5i].
- `req_data`  in  NUM_REQ*32  packed write data; requester i uses bits [32i+31:32i].
- `req_ready`  out  NUM_REQ  one-hot grant; a transfer occurs when valid and ready are both high on a rising edge.
- `ctrl_regwrite`  out  1  register-file write enable (flop).
- `write_w`  out  5  register-file write address (flop).
- `write_data_w`  out  32  register-file write data (flop).
- `init_done`  out  1  high once arbitration is enabled.

## Operation
- FSM states are CLEAR and RUN.
  - Reset state is CLEAR when CLEAR_ON_RESET=1, otherwise RUN.
- **CLEAR:**
  - A 5-bit counter `clr_cnt` (reset 0) drives the outputs each cycle: `ctrl_regwrite`=1, `write_w`=`clr_cnt`, `write_data_w`=0.
  - The counter then increments.
  - On the edge that loads address 31, the state moves to RUN.
  - `req_ready` is all-zero throughout CLEAR.
- **RUN, arbitration:**
  - Pointer `last` resets to NUM_REQ-1.
  - The grant goes to the first i with `req_valid[i]`=1, searching `last`+1, `last`+2, … modulo NUM_REQ.
  - `req_ready` is the combinational one-hot of that grant and is zero when no request is valid.
  - On each transfer, `last` is set to the granted index. With no transfer, `last` holds.
- **Write issue:**
  - On a transfer, the next edge loads `write_w`/`write_data_w` from the granted requester.
  - `ctrl_regwrite` is loaded as 1, except when the address is 0; register $zero is never written.
  - A write to address 0 still completes the handshake and advances `last`.
- **No transfer:** `ctrl_regwrite` loads 0; `write_w` and `write_data_w` hold their previous values.
- **Requester rule:** once valid, a requester must hold valid, addr and data stable until it sees ready. The block does not check this.
- **Same address from two requesters in one cycle:** only one is granted. The loser writes in a later cycle, so the last granted write wins.
- **`rst` asserted mid-CLEAR or mid-RUN:**
  - All flops return to reset values immediately.
  - Any write loaded but not yet performed by the register file is dropped.
  - The clear sequence restarts at address 0.

## Timing
- **Reset values:** `ctrl_regwrite`=0, `write_w`=0, `write_data_w`=0, `req_ready`=0, `init_done`=~CLEAR_ON_RESET.
- **CLEAR_ON_RESET=1:**
  - The first rising edge after `rst` deassertion loads the clear of address 0.
  - Edges 1..32 load addresses 0..31.
  - `init_done` rises and `req_ready` is enabled after edge 32.
  - `ctrl_regwrite` is high for exactly 32 consecutive cycles.
- **Latency:** a transfer on edge N is presented on the write port during cycle N+1 and is captured by the register file at edge N+1.
- **Throughput:** one write per cycle sustained.
- **Fairness:** each continuously-valid requester is granted at least once every NUM_REQ transfers.
- **Path constraint:** no combinational path from `req_valid`/`req_addr`/`req_data` to any register-file port.

## Structure
- Shared package `regfile_pkg`:
  - constants `REG_ADDR_W`=5, `REG_DATA_W`=32, `NUM_REGS`=32, `ZERO_REG`=0;
  - the state typedef `wr_arb_state_t` {CLEAR, RUN}.
- One sub-module, `rr_arbiter`:
  - parameter `N`;
  - combinational one-hot grant from `req` and `last`;
  - owns the `last` pointer register and its update on `accept`.
- The top level holds the FSM, the clear counter, the output flops and the operand muxing.

## Test plan
- **Reset clear:** CLEAR_ON_RESET=1, release `rst` → 32 cycles of `ctrl_regwrite`=1 with `write_w` 0..31 and data 0; `init_done`=1 after edge 32; `req_ready`=0 throughout.
- **Round robin:** all three valid continuously with addrs 5/6/7 and data 0xA/0xB/0xC → grants 0,1,2,0,1,2; port shows (5,0xA),(6,0xB),(7,0xC) one cycle after each grant.
- **Zero register:** requester 1 writes addr 0, data 0xDEADBEEF → `req_ready[1]`=1, next cycle `ctrl_regwrite`=0; readback of r0 = 0.
- **Collision:** requesters 0 and 2 both target r9 with 0x11 and 0x22 in the same cycle from reset pointer → r0's write then r2's; final r9 = 0x22.
- **Reset mid-clear:** assert `rst` at clear address 17 → outputs zero immediately; after release, clear restarts at address 0 and runs a full 32 cycles.
- **Idle gaps:** a single valid pulse held one cycle → exactly one write, then `ctrl_regwrite`=0 with `write_w`/`write_data_w` held.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared register-file constants and the write-arbiter state type.
package regfile_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned REG_DATA_W = 32;
  localparam int unsigned NUM_REGS   = 32;
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } wr_arb_state_t;

endpackage

// File: rtl/regfile_wr_arbiter_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant searching from last+1,
// with the last-granted pointer updated on each accepted transfer.
module rr_arbiter #(
  parameter int unsigned N = 3
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [N-1:0]                         req,
  input  logic                                 accept,
  output logic [N-1:0]                         grant,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0] grant_idx
);

  localparam int unsigned LW = (N > 1) ? $clog2(N) : 1;

  logic [LW-1:0] last_q;
  logic [LW-1:0] last_d;
  logic          found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    for (int unsigned k = 1; k <= N; k++) begin
      if (!found && req[(32'(last_q) + k) % N]) begin
        found                           = 1'b1;
        grant[(32'(last_q) + k) % N]    = 1'b1;
        grant_idx                       = LW'((32'(last_q) + k) % N);
      end
    end
  end

  always_comb begin
    last_d = last_q;
    if (accept) begin
      last_d = grant_idx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= LW'(N - 1);
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Register-file write-port arbiter: optional post-reset clear of all registers,
// then round-robin sharing of the single write port among NUM_REQ sources.
module regfile_wr_arbiter
  import regfile_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 3,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_REQ-1:0]               req_valid,
  input  logic [NUM_REQ*REG_ADDR_W-1:0]    req_addr,
  input  logic [NUM_REQ*REG_DATA_W-1:0]    req_data,
  output logic [NUM_REQ-1:0]               req_ready,
  output logic                             ctrl_regwrite,
  output logic [REG_ADDR_W-1:0]            write_w,
  output logic [REG_DATA_W-1:0]            write_data_w,
  output logic                             init_done
);

  localparam wr_arb_state_t RESET_STATE = CLEAR_ON_RESET ? CLEAR : RUN;
  localparam int unsigned   IDX_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  wr_arb_state_t           state_q, state_d;
  logic [REG_ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
  logic                    regwrite_q, regwrite_d;
  logic [REG_ADDR_W-1:0]   waddr_q, waddr_d;
  logic [REG_DATA_W-1:0]   wdata_q, wdata_d;

  logic [NUM_REQ-1:0]      grant;
  logic [IDX_W-1:0]        grant_idx;
  logic                    accept;
  logic [REG_ADDR_W-1:0]   sel_addr;
  logic [REG_DATA_W-1:0]   sel_data;

  rr_arbiter #(
    .N (NUM_REQ)
  ) u_rr_arbiter (
    .clk       (clk),
    .rst       (rst),
    .req       (req_valid),
    .accept    (accept),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // Grant is already one-hot on a valid requester, so any valid in RUN is a transfer.
  assign req_ready = (state_q == RUN) ? grant : '0;
  assign accept    = (state_q == RUN) && (|req_valid);

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_addr = req_addr[i*REG_ADDR_W +: REG_ADDR_W];
        sel_data = req_data[i*REG_DATA_W +: REG_DATA_W];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    clr_cnt_d  = clr_cnt_q;
    regwrite_d = 1'b0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    unique case (state_q)
      CLEAR: begin
        regwrite_d = 1'b1;
        waddr_d    = clr_cnt_q;
        wdata_d    = '0;
        clr_cnt_d  = clr_cnt_q + 1'b1;
        if (clr_cnt_q == REG_ADDR_W'(NUM_REGS - 1)) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (accept) begin
          regwrite_d = (sel_addr != ZERO_REG);
          waddr_d    = sel_addr;
          wdata_d    = sel_data;
        end
      end
      default: state_d = RESET_STATE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RESET_STATE;
      clr_cnt_q  <= '0;
      regwrite_q <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      clr_cnt_q  <= clr_cnt_d;
      regwrite_q <= regwrite_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
    end
  end

  assign ctrl_regwrite = regwrite_q;
  assign write_w       = waddr_q;
  assign write_data_w  = wdata_q;
  assign init_done     = (state_q == RUN);

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for regfile_wr_arbiter (NUM_REQ=3, CLEAR_ON_RESET=1) with a
// small register-file memory that captures the write port on each edge.
module tb_regfile_wr_arbiter;

  logic          clk;
  logic          rst;
  logic [2:0]    req_valid;
  logic [14:0]   req_addr;
  logic [95:0]   req_data;
  logic [2:0]    req_ready;
  logic          ctrl_regwrite;
  logic [4:0]    write_w;
  logic [31:0]   write_data_w;
  logic          init_done;

  logic [31:0]   regs [32];
  int            n_cmp;
  int            n_mis;

  regfile_wr_arbiter #(
    .NUM_REQ        (3),
    .CLEAR_ON_RESET (1'b1)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_addr      (req_addr),
    .req_data      (req_data),
    .req_ready     (req_ready),
    .ctrl_regwrite (ctrl_regwrite),
    .write_w       (write_w),
    .write_data_w  (write_data_w),
    .init_done     (init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Plain memory: r0 is not protected here, so a stray r0 write is visible.
  always @(posedge clk) begin
    if (ctrl_regwrite) regs[write_w] <= write_data_w;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 3'b111; req_addr = '0; req_data = '0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (ctrl_regwrite !== 1'b0) begin n_mis++; $display("FAIL rst_we: got %b want 0", ctrl_regwrite); end
    n_cmp++; if (write_w !== 5'd0) begin n_mis++; $display("FAIL rst_addr: got %0d want 0", write_w); end
    n_cmp++; if (write_data_w !== 32'd0) begin n_mis++; $display("FAIL rst_data: got %h want 0", write_data_w); end
    n_cmp++; if (req_ready !== 3'b000) begin n_mis++; $display("FAIL rst_ready: got %b want 000", req_ready); end
    n_cmp++; if (init_done !== 1'b0) begin n_mis++; $display("FAIL rst_init: got %b want 0", init_done); end
    rst = 1'b0;
    for (int i = 0; i < 32; i++) begin
      tick();
      n_cmp++; if (ctrl_regwrite !== 1'b1) begin n_mis++; $display("FAIL clr_we[%0d]: got %b want 1", i, ctrl_regwrite); end
      n_cmp++; if (write_w !== 5'(i)) begin n_mis++; $display("FAIL clr_addr[%0d]: got %0d want %0d", i, write_w, i); end
      n_cmp++; if (write_data_w !== 32'd0) begin n_mis++; $display("FAIL clr_data[%0d]: got %h want 0", i, write_data_w); end
      if (i < 31) begin
        n_cmp++; if (req_ready !== 3'b000) begin n_mis++; $display("FAIL clr_ready[%0d]: got %b want 000", i, req_ready); end
        n_cmp++; if (init_done !== 1'b0) begin n_mis++; $display("FAIL clr_init[%0d]: got %b want 0", i, init_done); end
      end
    end
    n_cmp++; if (init_done !== 1'b1) begin n_mis++; $display("FAIL init_done_after32: got %b want 1", init_done); end
    n_cmp++; if (req_ready !== 3'b001) begin n_mis++; $display("FAIL first_ready: got %b want 001", req_ready); end
    req_valid = 3'b000;
    tick();
    n_cmp++; if (ctrl_regwrite !== 1'b0) begin n_mis++; $display("FAIL clr_end_we: got %b want 0", ctrl_regwrite); end
    n_cmp++; if (write_w !== 5'd31) begin n_mis++; $display("FAIL clr_end_hold: got %0d want 31", write_w); end
  endtask

  task automatic test_round_robin();
    logic [2:0]  exp_rdy [3];
    logic [4:0]  exp_a   [3];
    logic [31:0] exp_d   [3];
    exp_rdy = '{3'b001, 3'b010, 3'b100};
    exp_a   = '{5'd5, 5'd6, 5'd7};
    exp_d   = '{32'hA, 32'hB, 32'hC};
    req_addr  = {5'd7, 5'd6, 5'd5};
    req_data  = {32'hC, 32'hB, 32'hA};
    req_valid = 3'b111;
    #1;
    for (int k = 0; k < 6; k++) begin
      n_cmp++; if (req_ready !== exp_rdy[k%3]) begin n_mis++; $display("FAIL rr_grant[%0d]: got %b want %b", k, req_ready, exp_rdy[k%3]); end
      tick();
      n_cmp++; if (ctrl_regwrite !== 1'b1) begin n_mis++; $display("FAIL rr_we[%0d]: got %b want 1", k, ctrl_regwrite); end
      n_cmp++; if (write_w !== exp_a[k%3]) begin n_mis++; $display("FAIL rr_addr[%0d]: got %0d want %0d", k, write_w, exp_a[k%3]); end
      n_cmp++; if (write_data_w !== exp_d[k%3]) begin n_mis++; $display("FAIL rr_data[%0d]: got %h want %h", k, write_data_w, exp_d[k%3]); end
    end
    req_valid = 3'b000;
    tick();
    n_cmp++; if (regs[7] !== 32'hC) begin n_mis++; $display("FAIL rr_mem_r7: got %h want c", regs[7]); end
  endtask

  task automatic test_zero_reg();
    req_addr  = {5'd0, 5'd0, 5'd0};
    req_data  = {32'd0, 32'hDEADBEEF, 32'd0};
    req_valid = 3'b010;
    #1;
    n_cmp++; if (req_ready !== 3'b010) begin n_mis++; $display("FAIL zr_ready: got %b want 010", req_ready); end
    tick();
    req_valid = 3'b000;
    n_cmp++; if (ctrl_regwrite !== 1'b0) begin n_mis++; $display("FAIL zr_we: got %b want 0", ctrl_regwrite); end
    n_cmp++; if (write_data_w !== 32'hDEADBEEF) begin n_mis++; $display("FAIL zr_data: got %h want deadbeef", write_data_w); end
    tick();
    n_cmp++; if (regs[0] !== 32'd0) begin n_mis++; $display("FAIL zr_mem_r0: got %h want 0", regs[0]); end
    req_valid = 3'b111;
    #1;
    n_cmp++; if (req_ready !== 3'b100) begin n_mis++; $display("FAIL zr_ptr_adv: got %b want 100", req_ready); end
    req_valid = 3'b000;
    #1;
  endtask

  task automatic test_idle_gaps();
    req_addr  = {5'd0, 5'd0, 5'd12};
    req_data  = {32'd0, 32'd0, 32'h55};
    req_valid = 3'b001;
    #1;
    n_cmp++; if (req_ready !== 3'b001) begin n_mis++; $display("FAIL idle_ready: got %b want 001", req_ready); end
    tick();
    req_valid = 3'b000;
    #1;
    n_cmp++; if (req_ready !== 3'b000) begin n_mis++; $display("FAIL idle_ready_off: got %b want 000", req_ready); end
    n_cmp++; if (ctrl_regwrite !== 1'b1) begin n_mis++; $display("FAIL idle_we: got %b want 1", ctrl_regwrite); end
    n_cmp++; if (write_w !== 5'd12) begin n_mis++; $display("FAIL idle_addr: got %0d want 12", write_w); end
    for (int k = 0; k < 2; k++) begin
      tick();
      n_cmp++; if (ctrl_regwrite !== 1'b0) begin n_mis++; $display("FAIL idle_gap_we[%0d]: got %b want 0", k, ctrl_regwrite); end
      n_cmp++; if (write_w !== 5'd12) begin n_mis++; $display("FAIL idle_gap_addr[%0d]: got %0d want 12", k, write_w); end
      n_cmp++; if (write_data_w !== 32'h55) begin n_mis++; $display("FAIL idle_gap_data[%0d]: got %h want 55", k, write_data_w); end
    end
    n_cmp++; if (regs[12] !== 32'h55) begin n_mis++; $display("FAIL idle_mem_r12: got %h want 55", regs[12]); end
  endtask

  task automatic test_reset_mid_clear();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 18; i++) tick();
    n_cmp++; if (write_w !== 5'd17) begin n_mis++; $display("FAIL mid_pre_addr: got %0d want 17", write_w); end
    rst = 1'b1;
    #1;
    n_cmp++; if (ctrl_regwrite !== 1'b0) begin n_mis++; $display("FAIL mid_we: got %b want 0", ctrl_regwrite); end
    n_cmp++; if (write_w !== 5'd0) begin n_mis++; $display("FAIL mid_addr: got %0d want 0", write_w); end
    n_cmp++; if (init_done !== 1'b0) begin n_mis++; $display("FAIL mid_init: got %b want 0", init_done); end
    tick();
    rst = 1'b0;
    req_valid = 3'b111;
    for (int i = 0; i < 32; i++) begin
      tick();
      n_cmp++; if (ctrl_regwrite !== 1'b1) begin n_mis++; $display("FAIL re_clr_we[%0d]: got %b want 1", i, ctrl_regwrite); end
      n_cmp++; if (write_w !== 5'(i)) begin n_mis++; $display("FAIL re_clr_addr[%0d]: got %0d want %0d", i, write_w, i); end
      if (i < 31) begin
        n_cmp++; if (req_ready !== 3'b000) begin n_mis++; $display("FAIL re_clr_ready[%0d]: got %b want 000", i, req_ready); end
      end
    end
    n_cmp++; if (init_done !== 1'b1) begin n_mis++; $display("FAIL re_init: got %b want 1", init_done); end
    req_valid = 3'b000;
    tick();
    n_cmp++; if (regs[12] !== 32'd0) begin n_mis++; $display("FAIL re_mem_r12: got %h want 0", regs[12]); end
  endtask

  task automatic test_collision();
    req_addr  = {5'd9, 5'd0, 5'd9};
    req_data  = {32'h22, 32'd0, 32'h11};
    req_valid = 3'b101;
    #1;
    n_cmp++; if (req_ready !== 3'b001) begin n_mis++; $display("FAIL col_ready0: got %b want 001", req_ready); end
    tick();
    req_valid = 3'b100;
    #1;
    n_cmp++; if (write_data_w !== 32'h11) begin n_mis++; $display("FAIL col_data0: got %h want 11", write_data_w); end
    n_cmp++; if (req_ready !== 3'b100) begin n_mis++; $display("FAIL col_ready2: got %b want 100", req_ready); end
    tick();
    req_valid = 3'b000;
    n_cmp++; if (write_w !== 5'd9) begin n_mis++; $display("FAIL col_addr2: got %0d want 9", write_w); end
    n_cmp++; if (write_data_w !== 32'h22) begin n_mis++; $display("FAIL col_data2: got %h want 22", write_data_w); end
    tick();
    n_cmp++; if (regs[9] !== 32'h22) begin n_mis++; $display("FAIL col_mem_r9: got %h want 22", regs[9]); end
  endtask

  initial begin
    n_cmp = 0;
    n_mis = 0;
    test_reset();
    test_round_robin();
    test_zero_reg();
    test_idle_gaps();
    test_reset_mid_clear();
    test_collision();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
